// File: rtl/stage_memory.sv
// Pipeline MEM stage: issues load/store requests to data memory, builds store strobes, extends load data.
// Optional build macro MEM_MISALIGN_TRAP_EN adds misaligned-access detection and the mem_misaligned pulse.
module stage_memory #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      execute_rd,
  input  logic            execute_regfile_wr_enable,
  input  logic            execute_datamem_wr_enable,
  input  logic [1:0]      execute_result_src,
  input  logic [XLEN-1:0] execute_alu_result,
  input  logic [XLEN-1:0] execute_wr_datamem_data,
  input  logic [2:0]      execute_funct3,
  input  logic [XLEN-1:0] execute_instr_addr_plus,
  output logic [4:0]      mem_rd,
  output logic            mem_regfile_wr_enable,
  output logic [1:0]      mem_result_src,
  output logic [XLEN-1:0] mem_alu_result,
  output logic [XLEN-1:0] mem_read_data,
  output logic [XLEN-1:0] mem_instr_addr_plus,
  output logic            mem_stall,
  output logic            dmem_req,
  input  logic            dmem_ready,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_wstrb,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic            mem_misaligned,
`endif
  output logic [1:0]      dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [1:0]      off;
  logic            is_store;
  logic            mem_op;
  logic            misaligned;
  logic            trap;
  logic            op_go;
  logic            load_done;
  logic [2:0]      funct3_q;
  logic [1:0]      off_q;
  logic [4:0]      rd_q;
  logic            wr_en_q;
  logic [1:0]      result_src_q;
  logic [XLEN-1:0] alu_result_q;
  logic [XLEN-1:0] read_data_q;
  logic [XLEN-1:0] pc4_q;
  logic [7:0]      st_byte;
  logic [15:0]     st_half;

  assign off      = execute_alu_result[1:0];
  assign is_store = execute_datamem_wr_enable;
  assign mem_op   = is_store | (execute_result_src == 2'b01);

`ifdef MEM_MISALIGN_TRAP_EN
  logic misaligned_q;
  assign misaligned = mem_op &&
                      (((execute_funct3[1:0] == 2'b01) && off[0]) ||
                       ((execute_funct3[1:0] == 2'b10) && (off != 2'b00)));
  assign mem_misaligned = misaligned_q;
`else
  assign misaligned = 1'b0;
`endif

  assign trap  = (state_q == S_IDLE) && misaligned;
  assign op_go = mem_op && !misaligned;

  // Handshake: a request transfers in any cycle where dmem_req && dmem_ready; request fields
  // stay stable while dmem_req waits. Load data arrives later as a one-cycle dmem_rvalid pulse.
  always_comb begin
    state_d   = state_q;
    dmem_req  = 1'b0;
    mem_stall = 1'b0;
    load_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (op_go) begin
          dmem_req = 1'b1;
          if (dmem_ready) begin
            if (!is_store) begin
              state_d   = S_RESP;
              mem_stall = 1'b1;
            end
          end else begin
            state_d   = S_REQ;
            mem_stall = 1'b1;
          end
        end
      end
      S_REQ: begin
        dmem_req  = 1'b1;
        mem_stall = 1'b1;
        if (dmem_ready) begin
          if (is_store) begin
            state_d   = S_IDLE;
            mem_stall = 1'b0;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        mem_stall = 1'b1;
        if (dmem_rvalid) begin
          state_d   = S_IDLE;
          mem_stall = 1'b0;
          load_done = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Execute outputs are frozen by the stall, so request fields can come straight from them.
  assign st_byte   = execute_wr_datamem_data[7:0];
  assign st_half   = execute_wr_datamem_data[15:0];
  assign dmem_we   = is_store;
  assign dmem_addr = {execute_alu_result[XLEN-1:2], 2'b00};

  always_comb begin
    dmem_wstrb = 4'b1111;
    dmem_wdata = execute_wr_datamem_data;
    case (execute_funct3[1:0])
      2'b00: begin
        dmem_wstrb = 4'b0001 << off;
        dmem_wdata = {(XLEN/8){st_byte}};
      end
      2'b01: begin
        dmem_wstrb = 4'b0011 << {off[1], 1'b0};
        dmem_wdata = {(XLEN/16){st_half}};
      end
      default: ;
    endcase
  end

  function automatic logic [XLEN-1:0] extend_load(input logic [2:0] f3, input logic [1:0] o,
                                                  input logic [XLEN-1:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{o, 3'b000} +: 8];
    h = o[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  extend_load = {{(XLEN-8){b[7]}}, b};
      3'b001:  extend_load = {{(XLEN-16){h[15]}}, h};
      3'b010:  extend_load = w;
      3'b100:  extend_load = {{(XLEN-8){1'b0}}, b};
      3'b101:  extend_load = {{(XLEN-16){1'b0}}, h};
      default: extend_load = '0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      funct3_q     <= '0;
      off_q        <= '0;
      rd_q         <= '0;
      wr_en_q      <= 1'b0;
      result_src_q <= '0;
      alu_result_q <= '0;
      read_data_q  <= '0;
      pc4_q        <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == S_IDLE) && op_go) begin
        funct3_q <= execute_funct3;
        off_q    <= off;
      end
      // A stalled cycle inserts a bubble by dropping only the write enable.
      wr_en_q <= mem_stall ? 1'b0 : (execute_regfile_wr_enable && !trap);
      if (!mem_stall) begin
        rd_q         <= execute_rd;
        result_src_q <= execute_result_src;
        alu_result_q <= execute_alu_result;
        pc4_q        <= execute_instr_addr_plus;
      end
      if (load_done) begin
        read_data_q <= extend_load(funct3_q, off_q, dmem_rdata);
      end
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= trap;
    end
  end
`endif

  assign mem_rd                = rd_q;
  assign mem_regfile_wr_enable = wr_en_q;
  assign mem_result_src        = result_src_q;
  assign mem_alu_result        = alu_result_q;
  assign mem_read_data         = read_data_q;
  assign mem_instr_addr_plus   = pc4_q;
  assign dbg_state_o           = state_q;

endmodule

// File: tb/tb_stage_memory.sv
// Self-checking bench for stage_memory: directed test-plan cases plus randomized load/store traffic
// checked against an arithmetic reference model.
module tb_stage_memory;

  logic        clk;
  logic        rst_n;
  logic [4:0]  execute_rd;
  logic        execute_regfile_wr_enable;
  logic        execute_datamem_wr_enable;
  logic [1:0]  execute_result_src;
  logic [31:0] execute_alu_result;
  logic [31:0] execute_wr_datamem_data;
  logic [2:0]  execute_funct3;
  logic [31:0] execute_instr_addr_plus;
  logic [4:0]  mem_rd;
  logic        mem_regfile_wr_enable;
  logic [1:0]  mem_result_src;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_read_data;
  logic [31:0] mem_instr_addr_plus;
  logic        mem_stall;
  logic        dmem_req;
  logic        dmem_ready;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [1:0]  dbg_state_o;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        mem_misaligned;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] model_rd_data;
  logic [31:0] exp_q[$];

  stage_memory #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .execute_rd(execute_rd),
    .execute_regfile_wr_enable(execute_regfile_wr_enable),
    .execute_datamem_wr_enable(execute_datamem_wr_enable),
    .execute_result_src(execute_result_src),
    .execute_alu_result(execute_alu_result),
    .execute_wr_datamem_data(execute_wr_datamem_data),
    .execute_funct3(execute_funct3),
    .execute_instr_addr_plus(execute_instr_addr_plus),
    .mem_rd(mem_rd),
    .mem_regfile_wr_enable(mem_regfile_wr_enable),
    .mem_result_src(mem_result_src),
    .mem_alu_result(mem_alu_result),
    .mem_read_data(mem_read_data),
    .mem_instr_addr_plus(mem_instr_addr_plus),
    .mem_stall(mem_stall),
    .dmem_req(dmem_req),
    .dmem_ready(dmem_ready),
    .dmem_we(dmem_we),
    .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb),
    .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata),
`ifdef MEM_MISALIGN_TRAP_EN
    .mem_misaligned(mem_misaligned),
`endif
    .dbg_state_o(dbg_state_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain arithmetic on the access rules
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] w);
    int unsigned o, b, h;
    o = addr % 4;
    b = (w >> (8 * o)) % 256;
    h = (w >> (16 * (o / 2))) % 65536;
    case (f3)
      3'd0: return (b >= 128) ? (32'(b) - 32'd256) : 32'(b);
      3'd1: return (h >= 32768) ? (32'(h) - 32'd65536) : 32'(h);
      3'd2: return w;
      3'd4: return 32'(b);
      3'd5: return 32'(h);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [3:0] model_wstrb(input logic [2:0] f3, input logic [31:0] addr);
    int unsigned o;
    o = addr % 4;
    if (f3[1:0] == 2'd0) return 4'(1 << o);
    if (f3[1:0] == 2'd1) return 4'(3 << (2 * (o / 2)));
    return 4'd15;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3[1:0] == 2'd0) return (d % 256) * 32'h0101_0101;
    if (f3[1:0] == 2'd1) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  // Driver tasks
  task automatic clear_exec();
    execute_rd = '0;
    execute_regfile_wr_enable = 1'b0;
    execute_datamem_wr_enable = 1'b0;
    execute_result_src = 2'b00;
    execute_alu_result = '0;
    execute_wr_datamem_data = '0;
    execute_funct3 = '0;
    execute_instr_addr_plus = '0;
  endtask

  // Runs one access starting at posedge+1; reports what was observed, compares nothing.
  task automatic run_op(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] data, input logic [4:0] rd, input logic [31:0] pc4,
                        input int wait_n, input int lat, input logic [31:0] rdata,
                        output int stall_n, output int cyc_n, output int bubble_err,
                        output int unstable, output logic [31:0] s_addr,
                        output logic [31:0] s_wdata, output logic [3:0] s_wstrb,
                        output logic s_req, output bit timeout);
    int acc;
    bit done;
    logic st_now;
    execute_rd = rd;
    execute_regfile_wr_enable = !st;
    execute_datamem_wr_enable = st;
    execute_result_src = st ? 2'b00 : 2'b01;
    execute_alu_result = addr;
    execute_wr_datamem_data = data;
    execute_funct3 = f3;
    execute_instr_addr_plus = pc4;
    dmem_ready = (wait_n == 0);
    dmem_rvalid = 1'b0;
    dmem_rdata = rdata;
    stall_n = 0; cyc_n = 0; bubble_err = 0; unstable = 0;
    s_addr = '0; s_wdata = '0; s_wstrb = '0; s_req = 1'b0;
    acc = -1; done = 0;
    while (!done && cyc_n < 60) begin
      #4;
      if (cyc_n == 0) begin
        s_req = dmem_req; s_addr = dmem_addr; s_wdata = dmem_wdata; s_wstrb = dmem_wstrb;
      end else if (acc < 0 && (dmem_req !== s_req || dmem_addr !== s_addr ||
                               dmem_wdata !== s_wdata || dmem_wstrb !== s_wstrb ||
                               dmem_we !== st)) begin
        unstable++;
      end
      st_now = mem_stall;
      if (st_now === 1'b1) stall_n++;
      if (dmem_rvalid) done = 1;
      else if (acc < 0 && dmem_req === 1'b1 && dmem_ready) begin
        acc = cyc_n;
        if (st) done = 1;
      end
      @(posedge clk); #1;
      if (st_now === 1'b1 && mem_regfile_wr_enable !== 1'b0) bubble_err++;
      cyc_n++;
      dmem_ready = (acc < 0 && cyc_n >= wait_n);
      dmem_rvalid = (!st && acc >= 0 && cyc_n == acc + lat);
    end
    timeout = !done;
    dmem_ready = 1'b0;
    dmem_rvalid = 1'b0;
    clear_exec();
  endtask

  // Scenario tasks
  task automatic test_reset();
    rst_n = 1'b0;
    clear_exec();
    dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    repeat (3) @(posedge clk);
    #5 rst_n = 1'b1;
    @(posedge clk); #1;
    #4;
    checks++;
    if ({mem_rd, mem_regfile_wr_enable, mem_result_src} !== 8'd0 || mem_alu_result !== 0 ||
        mem_read_data !== 0 || mem_instr_addr_plus !== 0) begin
      errors++;
      $display("FAIL reset_regs got rd=%h we=%b src=%h alu=%h rdat=%h pc4=%h exp all 0",
               mem_rd, mem_regfile_wr_enable, mem_result_src, mem_alu_result, mem_read_data,
               mem_instr_addr_plus);
    end
    checks++;
    if (dmem_req !== 1'b0 || mem_stall !== 1'b0 || dbg_state_o !== 2'd0) begin
      errors++;
      $display("FAIL reset_comb got req=%b stall=%b state=%0d exp 0 0 0", dmem_req, mem_stall,
               dbg_state_o);
    end
    model_rd_data = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_store_word();
    int sn, cn, be, un; logic [31:0] a, wd; logic [3:0] ws; logic rq; bit to;
    run_op(1, 3'd2, 32'h100, 32'hDEADBEEF, 5'd0, 32'h44, 0, 0, 0,
           sn, cn, be, un, a, wd, ws, rq, to);
    checks++;
    if (rq !== 1'b1 || a !== 32'h100 || ws !== 4'b1111 || wd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL sw_request got req=%b addr=%h strb=%b wdata=%h exp 1 100 1111 deadbeef",
               rq, a, ws, wd);
    end
    checks++;
    if (sn !== 0 || cn !== 1 || to) begin
      errors++;
      $display("FAIL sw_stall got stall_cycles=%0d cycles=%0d timeout=%0d exp 0 1 0", sn, cn, to);
    end
    checks++;
    if (dbg_state_o !== 2'd0 || mem_regfile_wr_enable !== 1'b0) begin
      errors++;
      $display("FAIL sw_state got state=%0d we=%b exp 0 0", dbg_state_o, mem_regfile_wr_enable);
    end
  endtask

  task automatic test_store_byte();
    int sn, cn, be, un; logic [31:0] a, wd; logic [3:0] ws; logic rq; bit to;
    run_op(1, 3'd0, 32'h103, 32'h000000A5, 5'd0, 32'h48, 0, 0, 0,
           sn, cn, be, un, a, wd, ws, rq, to);
    checks++;
    if (ws !== 4'b1000 || wd !== 32'hA5A5A5A5 || a !== 32'h100 || sn !== 0) begin
      errors++;
      $display("FAIL sb_request got strb=%b wdata=%h addr=%h stall=%0d exp 1000 a5a5a5a5 100 0",
               ws, wd, a, sn);
    end
    checks++;
    if (mem_read_data !== model_rd_data) begin
      errors++;
      $display("FAIL sb_hold_rdata got %h exp %h", mem_read_data, model_rd_data);
    end
  endtask

  task automatic test_load_byte();
    int sn, cn, be, un; logic [31:0] a, wd; logic [3:0] ws; logic rq; bit to;
    run_op(0, 3'd0, 32'h102, 32'h0, 5'd7, 32'h1004, 0, 3, 32'h12F40000,
           sn, cn, be, un, a, wd, ws, rq, to);
    model_rd_data = 32'hFFFFFFF4;
    checks++;
    if (sn !== 3 || be !== 0 || to) begin
      errors++;
      $display("FAIL lb_stall got stall_cycles=%0d bubble_err=%0d timeout=%0d exp 3 0 0",
               sn, be, to);
    end
    checks++;
    if (mem_read_data !== 32'hFFFFFFF4) begin
      errors++;
      $display("FAIL lb_data got %h exp fffffff4", mem_read_data);
    end
    checks++;
    if (mem_regfile_wr_enable !== 1'b1 || mem_rd !== 5'd7 || mem_result_src !== 2'b01 ||
        mem_alu_result !== 32'h102 || mem_instr_addr_plus !== 32'h1004) begin
      errors++;
      $display("FAIL lb_pipe got we=%b rd=%0d src=%0d alu=%h pc4=%h exp 1 7 1 102 1004",
               mem_regfile_wr_enable, mem_rd, mem_result_src, mem_alu_result,
               mem_instr_addr_plus);
    end
  endtask

  task automatic test_load_half_unsigned();
    int sn, cn, be, un; logic [31:0] a, wd; logic [3:0] ws; logic rq; bit to;
    run_op(0, 3'd5, 32'h102, 32'h0, 5'd9, 32'h1008, 0, 2, 32'h80010000,
           sn, cn, be, un, a, wd, ws, rq, to);
    model_rd_data = 32'h00008001;
    checks++;
    if (mem_read_data !== 32'h00008001 || sn !== 2 || to) begin
      errors++;
      $display("FAIL lhu_data got %h stall=%0d exp 00008001 2", mem_read_data, sn);
    end
  endtask

  task automatic test_ready_wait();
    int sn, cn, be, un; logic [31:0] a, wd; logic [3:0] ws; logic rq; bit to;
    run_op(1, 3'd1, 32'h206, 32'h1234BEEF, 5'd0, 32'h50, 4, 0, 0,
           sn, cn, be, un, a, wd, ws, rq, to);
    checks++;
    if (un !== 0 || rq !== 1'b1 || ws !== 4'b1100 || wd !== 32'hBEEFBEEF || a !== 32'h204) begin
      errors++;
      $display("FAIL sh_wait_fields got unstable=%0d req=%b strb=%b wdata=%h addr=%h exp 0 1 1100 beefbeef 204",
               un, rq, ws, wd, a);
    end
    checks++;
    if (sn !== 4 || cn !== 5 || to || be !== 0) begin
      errors++;
      $display("FAIL sh_wait_stall got stall=%0d cycles=%0d timeout=%0d bubble_err=%0d exp 4 5 0 0",
               sn, cn, to, be);
    end
  endtask

  task automatic test_random();
    int sn, cn, be, un; logic [31:0] a, wd; logic [3:0] ws; logic rq; bit to;
    logic [2:0] ld_f3 [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    for (int n = 0; n < 40; n++) begin
      bit st; logic [2:0] f3; logic [31:0] addr, data, rdata, pc4; logic [4:0] rd;
      int wt, lat;
      st = ($urandom_range(0, 1) == 1);
      f3 = st ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 7)];
      addr = $urandom; data = $urandom; rdata = $urandom; pc4 = $urandom;
      rd = 5'($urandom_range(1, 31));
`ifdef MEM_MISALIGN_TRAP_EN
      if (f3[1:0] == 2'd1) addr[0] = 1'b0;
      if (f3[1:0] == 2'd2) addr[1:0] = 2'b00;
`endif
      wt = $urandom_range(0, 3);
      lat = $urandom_range(2, 5);
      if (!st) exp_q.push_back(model_load(f3, addr, rdata));
      run_op(st, f3, addr, data, rd, pc4, wt, lat, rdata, sn, cn, be, un, a, wd, ws, rq, to);
      checks++;
      if (to || be !== 0 || un !== 0 || sn !== (st ? wt : wt + lat)) begin
        errors++;
        $display("FAIL rand_flow[%0d] got timeout=%0d bubble_err=%0d unstable=%0d stall=%0d exp 0 0 0 %0d",
                 n, to, be, un, sn, st ? wt : wt + lat);
      end
      checks++;
      if (a !== {addr[31:2], 2'b00} || rq !== 1'b1) begin
        errors++;
        $display("FAIL rand_addr[%0d] got %h req=%b exp %h 1", n, a, rq, {addr[31:2], 2'b00});
      end
      if (st) begin
        checks++;
        if (ws !== model_wstrb(f3, addr) || wd !== model_wdata(f3, data)) begin
          errors++;
          $display("FAIL rand_store[%0d] got strb=%b wdata=%h exp %b %h", n, ws, wd,
                   model_wstrb(f3, addr), model_wdata(f3, data));
        end
      end else begin
        model_rd_data = exp_q.pop_front();
      end
      checks++;
      if (mem_read_data !== model_rd_data || mem_regfile_wr_enable !== !st ||
          mem_rd !== rd || mem_instr_addr_plus !== pc4 || mem_alu_result !== addr) begin
        errors++;
        $display("FAIL rand_result[%0d] got rdat=%h we=%b rd=%0d pc4=%h alu=%h exp %h %b %0d %h %h",
                 n, mem_read_data, mem_regfile_wr_enable, mem_rd, mem_instr_addr_plus,
                 mem_alu_result, model_rd_data, !st, rd, pc4, addr);
      end
    end
  endtask

  task automatic test_reset_mid_access();
    execute_rd = 5'd3;
    execute_regfile_wr_enable = 1'b1;
    execute_result_src = 2'b01;
    execute_alu_result = 32'h300;
    execute_funct3 = 3'd2;
    dmem_ready = 1'b1;
    @(posedge clk); #1;
    dmem_ready = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (dbg_state_o !== 2'd2 || mem_stall !== 1'b1) begin
      errors++;
      $display("FAIL mid_in_resp got state=%0d stall=%b exp 2 1", dbg_state_o, mem_stall);
    end
    rst_n = 1'b0;
    clear_exec();
    #2;
    checks++;
    if (dbg_state_o !== 2'd0 || mem_stall !== 1'b0 || dmem_req !== 1'b0 ||
        mem_read_data !== 0 || mem_rd !== 0 || mem_regfile_wr_enable !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got state=%0d stall=%b req=%b rdat=%h rd=%0d we=%b exp all 0",
               dbg_state_o, mem_stall, dmem_req, mem_read_data, mem_rd, mem_regfile_wr_enable);
    end
    #2 rst_n = 1'b1;
    model_rd_data = '0;
    @(posedge clk); #1;
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'hCAFE0001;
    #4;
    checks++;
    if (mem_stall !== 1'b0) begin
      errors++;
      $display("FAIL late_rvalid_stall got %b exp 0", mem_stall);
    end
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    checks++;
    if (dbg_state_o !== 2'd0 || mem_read_data !== 32'd0) begin
      errors++;
      $display("FAIL late_rvalid_ignored got state=%0d rdat=%h exp 0 0", dbg_state_o,
               mem_read_data);
    end
  endtask

`ifdef MEM_MISALIGN_TRAP_EN
  task automatic test_misaligned();
    execute_rd = 5'd4;
    execute_regfile_wr_enable = 1'b1;
    execute_result_src = 2'b01;
    execute_alu_result = 32'h101;
    execute_funct3 = 3'd2;
    dmem_ready = 1'b1;
    #4;
    checks++;
    if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
      errors++;
      $display("FAIL misalign_req got req=%b stall=%b exp 0 0", dmem_req, mem_stall);
    end
    @(posedge clk); #1;
    clear_exec();
    dmem_ready = 1'b0;
    checks++;
    if (mem_misaligned !== 1'b1 || mem_regfile_wr_enable !== 1'b0) begin
      errors++;
      $display("FAIL misalign_pulse got mis=%b we=%b exp 1 0", mem_misaligned,
               mem_regfile_wr_enable);
    end
    @(posedge clk); #1;
    checks++;
    if (mem_misaligned !== 1'b0) begin
      errors++;
      $display("FAIL misalign_clear got %b exp 0", mem_misaligned);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_store_word();
    test_store_byte();
    test_load_byte();
    test_load_half_unsigned();
    test_ready_wait();
    test_random();
    test_reset_mid_access();
`ifdef MEM_MISALIGN_TRAP_EN
    test_misaligned();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
